// File: rtl/can_pkg.sv
// Shared CAN receive-path types, constants and the CRC-15 step function.
package can_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    CRC,
    TAIL
  } rx_state_t;

  localparam logic [14:0] CAN_CRC_POLY  = 15'h4599;
  localparam int unsigned CAN_STUFF_LEN = 5;
  localparam int unsigned CAN_HDR_BITS  = 18;
  localparam int unsigned CAN_CRC_BITS  = 15;

  // One serial CRC-15 update with data bit b.
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b,
                                             input logic [14:0] poly);
    logic fb;
    fb = b ^ crc[14];
    return {crc[13:0], 1'b0} ^ (fb ? poly : 15'h0000);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CRC-15 register. clear and shift together load the first-bit update of zero.
module can_crc15
  import can_pkg::*;
#(
  parameter logic [14:0] CRC_POLY = CAN_CRC_POLY
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic        bit_i,
  output logic [14:0] crc_o
);

  logic [14:0] crc_q, crc_d, base;

  // Next CRC value: optional clear, then optional one-bit update.
  always_comb begin
    base  = clear_i ? 15'h0000 : crc_q;
    crc_d = base;
    if (shift_i) begin
      crc_d = crc15_step(base, bit_i, CRC_POLY);
    end
  end

  // CRC state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_q <= 15'h0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/can_rx_destuff_crc.sv
// CAN receive destuffer, frame field tracker and CRC-15 accumulator for standard frames.
module can_rx_destuff_crc
  import can_pkg::*;
#(
  parameter logic [14:0] CRC_POLY  = CAN_CRC_POLY,
  parameter int unsigned STUFF_LEN = CAN_STUFF_LEN,
  parameter int unsigned MAX_BYTES = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        bit_valid_i,
  input  logic        rxd_i,
  input  logic        abort_i,
  output logic        rx_bit_o,
  output logic        rx_bit_valid_o,
  output logic        crc_field_en_o,
  output logic [14:0] crc_calculated_o,
  output logic [3:0]  dlc_o,
  output logic        frame_done_o,
  output logic        stuff_error_o
);

  localparam int unsigned RunW = $clog2(STUFF_LEN + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(STUFF_LEN);
  // Header bit positions counted from the first ID bit.
  localparam logic [6:0] HdrRtr  = 7'd11;
  localparam logic [6:0] HdrIde  = 7'd12;
  localparam logic [6:0] HdrLast = 7'(CAN_HDR_BITS - 1);
  localparam logic [6:0] CrcLast = 7'(CAN_CRC_BITS - 1);
  localparam logic [3:0] MaxBytes = 4'(MAX_BYTES);

  rx_state_t       state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            last_q, last_d;
  logic [RunW-1:0] run_q, run_d;
  logic            rtr_q, rtr_d;
  logic [2:0]      sr_q, sr_d;
  logic [3:0]      bytes_q, bytes_d;
  logic [3:0]      dlc_q, dlc_d;
  logic            rx_bit_q, rx_bit_d;
  logic            rx_valid_q, rx_valid_d;
  logic            crc_en_q, crc_en_d;
  logic            done_q, done_d;
  logic            serr_q, serr_d;
  logic            crc_clear, crc_shift;
  logic [6:0]      data_last;
  logic [3:0]      dlc_full;

  assign data_last = {bytes_q, 3'b000} - 7'd1;
  assign dlc_full  = {sr_q, rxd_i};

  // Next-state: SOF detect, destuffing, field tracking and registered output pulses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    run_d      = run_q;
    rtr_d      = rtr_q;
    sr_d       = sr_q;
    bytes_d    = bytes_q;
    dlc_d      = dlc_q;
    rx_bit_d   = rx_bit_q;
    rx_valid_d = 1'b0;
    crc_en_d   = 1'b0;
    done_d     = 1'b0;
    serr_d     = 1'b0;
    crc_clear  = 1'b0;
    crc_shift  = 1'b0;

    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = 7'd0;
      run_d   = '0;
    end else if (bit_valid_i) begin
      if (state_q == IDLE) begin
        if (!rxd_i) begin
          state_d    = HEADER;
          cnt_d      = 7'd0;
          last_d     = 1'b0;
          run_d      = RunW'(1);
          rx_bit_d   = 1'b0;
          rx_valid_d = 1'b1;
          crc_clear  = 1'b1;
          crc_shift  = 1'b1;
        end
      end else if (run_q == RunMax) begin
        // Stuff bit slot: must differ from the run it breaks.
        if (rxd_i == last_q) begin
          serr_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = 7'd0;
          run_d   = '0;
        end else begin
          last_d = rxd_i;
          run_d  = RunW'(1);
          if (state_q == TAIL) begin
            done_d  = 1'b1;
            state_d = IDLE;
            cnt_d   = 7'd0;
          end
        end
      end else begin
        rx_bit_d   = rxd_i;
        rx_valid_d = 1'b1;
        cnt_d      = cnt_q + 7'd1;
        if (rxd_i == last_q) begin
          run_d = run_q + RunW'(1);
        end else begin
          last_d = rxd_i;
          run_d  = RunW'(1);
        end
        case (state_q)
          HEADER: begin
            crc_shift = 1'b1;
            sr_d      = {sr_q[1:0], rxd_i};
            if (cnt_q == HdrRtr) begin
              rtr_d = rxd_i;
            end
            if (cnt_q == HdrIde && rxd_i) begin
              // Extended frames are not handled by this stage.
              serr_d  = 1'b1;
              state_d = IDLE;
              cnt_d   = 7'd0;
            end else if (cnt_q == HdrLast) begin
              dlc_d   = dlc_full;
              bytes_d = (dlc_full > MaxBytes) ? MaxBytes : dlc_full;
              cnt_d   = 7'd0;
              state_d = (bytes_d != 4'd0 && !rtr_q) ? DATA : CRC;
            end
          end
          DATA: begin
            crc_shift = 1'b1;
            if (cnt_q == data_last) begin
              cnt_d   = 7'd0;
              state_d = CRC;
            end
          end
          CRC: begin
            crc_en_d = 1'b1;
            if (cnt_q == CrcLast) begin
              cnt_d = 7'd0;
              if (run_d == RunMax) begin
                state_d = TAIL;
              end else begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end
          end
          default: begin
            // TAIL always sees a stuff slot; anything else resynchronises to IDLE.
            rx_valid_d = 1'b0;
            state_d    = IDLE;
            cnt_d      = 7'd0;
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cnt_q      <= 7'd0;
      last_q     <= 1'b0;
      run_q      <= '0;
      rtr_q      <= 1'b0;
      sr_q       <= 3'd0;
      bytes_q    <= 4'd0;
      dlc_q      <= 4'd0;
      rx_bit_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      crc_en_q   <= 1'b0;
      done_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      run_q      <= run_d;
      rtr_q      <= rtr_d;
      sr_q       <= sr_d;
      bytes_q    <= bytes_d;
      dlc_q      <= dlc_d;
      rx_bit_q   <= rx_bit_d;
      rx_valid_q <= rx_valid_d;
      crc_en_q   <= crc_en_d;
      done_q     <= done_d;
      serr_q     <= serr_d;
    end
  end

  can_crc15 #(
    .CRC_POLY(CRC_POLY)
  ) u_crc (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear_i(crc_clear),
    .shift_i(crc_shift),
    .bit_i  (rxd_i),
    .crc_o  (crc_calculated_o)
  );

  assign rx_bit_o       = rx_bit_q;
  assign rx_bit_valid_o = rx_valid_q;
  assign crc_field_en_o = crc_en_q;
  assign dlc_o          = dlc_q;
  assign frame_done_o   = done_q;
  assign stuff_error_o  = serr_q;

endmodule
